// File: rtl/riscv_pkg.sv
// RV32 shared decode definitions: opcodes, immediate formats, instruction fields,
// and source-usage helpers.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
   } imm_fmt_e;

   // Field order matches the instruction word, so a 32-bit cast decodes it.
   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } fields_t;

   function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
      case (opc)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: return IMM_I;
         OPC_STORE:                      return IMM_S;
         OPC_BRANCH:                     return IMM_B;
         OPC_LUI, OPC_AUIPC:             return IMM_U;
         OPC_JAL:                        return IMM_J;
         default:                        return IMM_NONE;
      endcase
   endfunction

   function automatic logic uses_rs1(input logic [6:0] opc);
      return !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opc);
      return opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Instruction word to sign-extended 32-bit immediate; combinational, 0 latency.
// No flow control; unknown opcodes and R-type produce 0.
module imm_decode
   import riscv_pkg::*;
(
   input  logic [31:0] inst,
   output logic [31:0] imm
);

   always_comb begin
      imm = '0;
      case (imm_fmt(inst[6:0]))
         IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {inst[31:12], 12'b0};
         IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// RV32 decode: regfile read with WB bypass, load-use scoreboard, one-entry ID/EX slot.
// Latency 1 cycle; in_ready drops on a load-use hazard or when a full slot is not drained.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN   = riscv_pkg::XLEN,
   parameter int NREGS  = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rdata1,
   output logic [XLEN-1:0] out_rdata2,
   output logic [XLEN-1:0] out_imm,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic            out_is_load,
   output logic            hazard_stall
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0] regs [NREGS];
   logic [NREGS-1:0] busy;
   fields_t         dec_f, slot_f;
   logic [31:0]     imm32;
   logic [XLEN-1:0] rdata1, rdata2;
   logic            fwd1, fwd2, haz1, haz2, accept;

   // Excludes x0 and, for RV32E, the upper sixteen addresses.
   function automatic logic arch_reg(input logic [4:0] a);
      return (a != 5'd0) && (int'(a) < NREGS);
   endfunction

   assign dec_f = fields_t'(in_inst);

   imm_decode u_imm (.inst(in_inst), .imm(imm32));

   assign fwd1 = BYPASS && wb_en && (wb_rd == dec_f.rs1);
   assign fwd2 = BYPASS && wb_en && (wb_rd == dec_f.rs2);

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (arch_reg(dec_f.rs1)) rdata1 = fwd1 ? wb_data : regs[dec_f.rs1[AW-1:0]];
      if (arch_reg(dec_f.rs2)) rdata2 = fwd2 ? wb_data : regs[dec_f.rs2[AW-1:0]];
   end

   // A busy source whose writeback lands this cycle is released only when bypass can deliver it.
   assign haz1 = uses_rs1(dec_f.opcode) && (dec_f.rs1 != 5'd0) &&
                 ((arch_reg(dec_f.rs1) && busy[dec_f.rs1[AW-1:0]] && !fwd1) ||
                  (out_valid && out_is_load && (out_rd == dec_f.rs1)));
   assign haz2 = uses_rs2(dec_f.opcode) && (dec_f.rs2 != 5'd0) &&
                 ((arch_reg(dec_f.rs2) && busy[dec_f.rs2[AW-1:0]] && !fwd2) ||
                  (out_valid && out_is_load && (out_rd == dec_f.rs2)));

   assign hazard_stall = in_valid && (haz1 || haz2);
   assign in_ready     = !hazard_stall && (!out_valid || out_ready);
   assign accept       = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_en && arch_reg(wb_rd)) begin
         regs[wb_rd[AW-1:0]] <= wb_data;
      end
   end

   // The set is written last so it overrides a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (wb_en && arch_reg(wb_rd)) busy[wb_rd[AW-1:0]] <= 1'b0;
         if (out_valid && out_ready && out_is_load && arch_reg(out_rd))
            busy[out_rd[AW-1:0]] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_pc      <= '0;
         out_rdata1  <= '0;
         out_rdata2  <= '0;
         out_imm     <= '0;
         slot_f      <= '0;
         out_is_load <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_pc      <= in_pc;
         out_rdata1  <= rdata1;
         out_rdata2  <= rdata2;
         out_imm     <= XLEN'($signed(imm32));
         slot_f      <= dec_f;
         out_is_load <= (dec_f.opcode == OPC_LOAD);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign out_opcode = slot_f.opcode;
   assign out_funct3 = slot_f.funct3;
   assign out_funct7 = slot_f.funct7;
   assign out_rs1    = slot_f.rs1;
   assign out_rs2    = slot_f.rs2;
   assign out_rd     = slot_f.rd;

endmodule
